// File: rtl/spi_slave_responder_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI responder endpoint: frame-decoder state
//   encoding, command-byte field values and the device addresses that the
//   responders on this chip-select bus answer to.
// ---------------------------------------------------------------------------
package spi_pkg;

    // Frame-decoder states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WR     = 3'd2,
        RD     = 3'd3,
        DONE   = 3'd4,
        IGNORE = 3'd5
    } state_t;

    // Command byte is {rw, dev_addr[6:0]}; rw = 1 selects a write frame.
    localparam logic RW_WRITE = 1'b1;
    localparam int   CMD_BITS = 8;

    // Responder addresses present on the bus.
    localparam logic [6:0] ADDR_51 = 7'h51;
    localparam logic [6:0] ADDR_52 = 7'h52;
    localparam logic [6:0] ADDR_53 = 7'h53;
    localparam logic [6:0] ADDR_54 = 7'h54;
    localparam logic [6:0] ADDR_55 = 7'h55;

endpackage

// File: rtl/spi_rx_fifo.sv
// ---------------------------------------------------------------------------
// spi_rx_fifo
//   Synchronous FIFO holding bytes received by write frames until local logic
//   consumes them. The head is presented with a valid/ready handshake.
//
//   Ports:
//     clk, rst        system clock, synchronous active-high reset
//     push, push_data write request and byte; ignored when full unless a pop
//                     happens in the same clk
//     full, empty     occupancy flags
//     out_data        head entry (reads as zero while empty)
//     out_valid       FIFO not empty
//     out_ready       pops the head when high together with out_valid
//
//   WIDTH >= 1, DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;     // extra wrap bit separates full from empty

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign do_pop  = out_ready && !empty;
    // A pop in the same clk frees the slot, so a push into a full FIFO succeeds.
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are meaningful, and leaving the array out of reset
    // lets it map onto plain register-file cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
//   SPI responder for one chip-select line. Decodes two-byte frames: a command
//   byte {rw, dev_addr[6:0]} sent MSB first, then one data byte sent LSB
//   first. Write frames push the data byte into the RX FIFO; read frames
//   return the byte preloaded through tx_data/tx_load. sclk, cs_n and mosi are
//   oversampled on clk through synchronizers; sclk idles high and mosi is
//   sampled on sclk rising edges.
//
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     sclk, cs_n, mosi  SPI bus inputs (asynchronous to clk)
//     miso, miso_oe     SPI data out and its drive enable
//     rx_data, rx_valid RX FIFO head and not-empty flag
//     rx_ready          pops the RX FIFO head
//     tx_data, tx_load  byte for the next read frame and its capture strobe
//     tx_empty          TX holding register is empty
//     overflow          sticky: write byte dropped because the FIFO was full
//     underrun          sticky: read frame started with nothing loaded
//     err_clr           clears overflow and underrun
//     busy              frame in progress (not IDLE and not IGNORE)
// ---------------------------------------------------------------------------
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int         DATA_WIDTH  = 7,
    parameter logic [6:0] DEV_ADDR    = ADDR_51,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    output logic [DATA_WIDTH:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic [DATA_WIDTH:0] tx_data,
    input  logic                tx_load,
    output logic                tx_empty,
    output logic                overflow,
    output logic                underrun,
    input  logic                err_clr,
    output logic                busy
);

    localparam int BW    = DATA_WIDTH + 1;
    localparam int MAXB  = (BW > CMD_BITS) ? BW : CMD_BITS;
    localparam int CNT_W = $clog2(MAXB);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BW - 1);

    // -----------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -----------------------------------------------------------------------
    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;

    assign pin_raw = {sclk, cs_n, mosi};

    // The chains are not reset: they keep tracking the pins through reset so
    // that releasing reset never fabricates an edge (a cs_n held low across
    // reset must not look like a fresh frame start).
    for (genvar g = 0; g < 3; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;

        // NOTE: sequential state is always updated with non-blocking
        // assignments so every flop samples the pre-edge value of its source,
        // independent of process evaluation order.
        always_ff @(posedge clk) begin
            chain <= SYNC_STAGES'({chain, pin_raw[g]});
        end

        assign pin_sync[g] = chain[SYNC_STAGES-1];
    end

    assign sclk_s = pin_sync[2];
    assign cs_s   = pin_sync[1];
    assign mosi_s = pin_sync[0];

    logic sclk_prev;
    logic cs_prev;
    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    // Previous-value registers follow the synchronized pins, also in reset,
    // for the same no-fabricated-edge reason as above.
    always_ff @(posedge clk) begin
        sclk_prev <= sclk_s;
        cs_prev   <= cs_s;
    end

    assign sclk_rise = sclk_s && !sclk_prev;
    assign cs_fall   = !cs_s && cs_prev;
    assign cs_rise   = cs_s && !cs_prev;

    // -----------------------------------------------------------------------
    // Frame decoder
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       cmd_sr;       // first seven command bits, MSB first
    logic [BW-2:0]    data_sr;      // data bits so far, LSB arriving first
    logic [7:0]       cmd_next;     // command byte including the current bit
    logic [BW-1:0]    wr_next;      // data byte including the current bit
    logic             rd_start;
    logic             rd_shift;
    logic             wr_done;
    logic             oe_next;

    assign cmd_next = {cmd_sr, mosi_s};
    assign wr_next  = {mosi_s, data_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state_q;
        rd_start   = 1'b0;
        rd_shift   = 1'b0;
        wr_done    = 1'b0;

        if (cs_rise) begin
            // Deselect aborts whatever is in flight; partial bytes are lost.
            next_state = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        next_state = CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise && bit_cnt == CMD_LAST) begin
                        if (cmd_next[6:0] != DEV_ADDR) begin
                            next_state = IGNORE;
                        end else if (cmd_next[7] == RW_WRITE) begin
                            next_state = WR;
                        end else begin
                            next_state = RD;
                            rd_start   = 1'b1;
                        end
                    end
                end
                WR: begin
                    if (sclk_rise && bit_cnt == DATA_LAST) begin
                        wr_done    = 1'b1;
                        next_state = DONE;
                    end
                end
                RD: begin
                    if (sclk_rise) begin
                        rd_shift = 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                            next_state = DONE;
                        end
                    end
                end
                DONE, IGNORE: begin
                    next_state = state_q;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end

        // MISO is owned from the read load until deselect; a DONE reached
        // from WR keeps it released because miso_oe was never set.
        oe_next = (next_state == RD) || ((next_state == DONE) && miso_oe);
    end

    assign busy = (state_q != IDLE) && (state_q != IGNORE);

    // -----------------------------------------------------------------------
    // Datapath: shift registers, TX holding register, sticky errors
    // -----------------------------------------------------------------------
    logic [BW-1:0] tx_hold;
    logic [BW-1:0] tx_sr;
    logic [BW-1:0] load_byte;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          overflow_set;
    logic          underrun_set;

    // An empty holding register returns all ones on the bus.
    assign load_byte    = tx_empty ? '1 : tx_hold;
    assign fifo_pop     = rx_ready && !fifo_empty;
    assign overflow_set = wr_done && fifo_full && !fifo_pop;
    assign underrun_set = rd_start && tx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            data_sr  <= '0;
            tx_sr    <= '1;
            tx_hold  <= '0;
            tx_empty <= 1'b1;
            miso     <= 1'b1;
            miso_oe  <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            // Every state change starts a new byte.
            if (next_state != state_q) begin
                bit_cnt <= '0;
            end else if (sclk_rise && (state_q inside {CMD, WR, RD})) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state_q == CMD && sclk_rise) begin
                cmd_sr <= cmd_next[6:0];
            end

            if (state_q == WR && sclk_rise) begin
                data_sr <= wr_next[BW-1:1];
            end

            // Bit 0 goes out with the load; each later controller rising
            // edge advances one bit so the next bit settles well before the
            // following rising edge. Ones fill in behind the data.
            if (rd_start) begin
                miso  <= load_byte[0];
                tx_sr <= {1'b1, load_byte[BW-1:1]};
            end else if (rd_shift) begin
                miso  <= tx_sr[0];
                tx_sr <= {1'b1, tx_sr[BW-1:1]};
            end else if (!oe_next) begin
                miso <= 1'b1;
            end
            miso_oe <= oe_next;

            // A load coinciding with the read load keeps the new byte held;
            // the old one has already been taken by load_byte above.
            if (tx_load) begin
                tx_hold  <= tx_data;
                tx_empty <= 1'b0;
            end else if (rd_start) begin
                tx_empty <= 1'b1;
            end

            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (err_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // RX FIFO
    // -----------------------------------------------------------------------
    spi_rx_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_done),
        .push_data (wr_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .out_data  (rx_data),
        .out_valid (rx_valid),
        .out_ready (rx_ready)
    );

endmodule

// File: tb/tb_spi_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_responder
//   Drives SPI frames as a bus controller would (sclk idle high, half-period
//   of HALF clk, mosi changed while sclk is low, miso read at the rising
//   edge) and compares the responder against a frame-level model: a byte
//   queue for the RX FIFO, a held byte plus empty flag for TX, and two sticky
//   error flags.
// ---------------------------------------------------------------------------
module tb_spi_slave_responder;
    import spi_pkg::*;

    localparam int         HALF     = 4;
    localparam int         DEPTH    = 4;
    localparam logic [6:0] DEV_ADDR = ADDR_51;
    localparam int         NO_RST   = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_empty;
    logic       overflow;
    logic       underrun;
    logic       err_clr;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Frame-level reference model.
    logic [7:0] m_q[$];
    logic [7:0] m_hold;
    logic       m_tx_empty;
    logic       m_overflow;
    logic       m_underrun;

    always #5 clk = ~clk;

    spi_slave_responder #(
        .DATA_WIDTH  (7),
        .DEV_ADDR    (DEV_ADDR),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_empty (tx_empty),
        .overflow (overflow),
        .underrun (underrun),
        .err_clr  (err_clr),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold     = 8'h00;
        m_tx_empty = 1'b1;
        m_overflow = 1'b0;
        m_underrun = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_rx_valid"}, rx_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check({tag, "_rx_data"}, rx_data, m_q[0]);
        end
        check_bit({tag, "_tx_empty"}, tx_empty, m_tx_empty);
        check_bit({tag, "_overflow"}, overflow, m_overflow);
        check_bit({tag, "_underrun"}, underrun, m_underrun);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_miso_oe"}, miso_oe, 1'b0);
        check_bit({tag, "_miso"}, miso, 1'b1);
    endtask

    // One controller frame. data_bits < 8 deselects early; rst_at < data_bits
    // pulses rst before that data bit while cs_n stays low.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                             input int data_bits, input int rst_at);
        logic       match;
        logic       is_rd;
        logic       did_rst;
        logic       oe_exp;
        logic [7:0] exp_rd;
        logic [7:0] got;

        match   = (cmd[6:0] == DEV_ADDR);
        is_rd   = match && (cmd[7] != RW_WRITE);
        did_rst = (rst_at < data_bits);
        oe_exp  = is_rd;
        exp_rd  = m_tx_empty ? 8'hFF : m_hold;
        if (is_rd) begin
            if (m_tx_empty) m_underrun = 1'b1;
            m_tx_empty = 1'b1;
        end
        got = 8'hFF;

        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = cmd[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < data_bits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (4) @(negedge clk);
                rst    = 1'b0;
                oe_exp = 1'b0;
                model_reset();
            end
            sclk = 1'b0;
            mosi = data[i];
            repeat (HALF) @(negedge clk);
            check_bit({tag, "_oe_bit"}, miso_oe, oe_exp);
            got[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        check_bit({tag, "_busy_sel"}, busy, match && !did_rst);
        cs_n = 1'b1;
        mosi = 1'b1;
        repeat (8) @(negedge clk);

        if (match && !is_rd && data_bits == 8 && !did_rst) begin
            if (m_q.size() == DEPTH) m_overflow = 1'b1;
            else m_q.push_back(data);
        end
        if (is_rd && data_bits == 8 && !did_rst) begin
            check({tag, "_rd_byte"}, got, exp_rd);
        end
        check_idle(tag);
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_pop_data"}, rx_data, m_q[0]);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(m_q.pop_front());
        check_bit({tag, "_pop_valid"}, rx_valid, m_q.size() != 0);
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load    = 1'b0;
        m_hold     = v;
        m_tx_empty = 1'b0;
        check_bit("tx_empty_after_load", tx_empty, 1'b0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr    = 1'b0;
        m_overflow = 1'b0;
        m_underrun = 1'b0;
        check_bit("err_clr_overflow", overflow, 1'b0);
        check_bit("err_clr_underrun", underrun, 1'b0);
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] data;
        int         nbits;

        rst      = 1'b1;
        sclk     = 1'b1;
        cs_n     = 1'b1;
        mosi     = 1'b1;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        tx_load  = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);

        // Reset values.
        check_bit("rst_miso", miso, 1'b1);
        check_bit("rst_miso_oe", miso_oe, 1'b0);
        check_bit("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check_bit("rst_tx_empty", tx_empty, 1'b1);
        check_bit("rst_overflow", overflow, 1'b0);
        check_bit("rst_underrun", underrun, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic write, then consume it.
        run_frame("wr_a5", 8'hD1, 8'hA5, 8, NO_RST);
        pop_one("wr_a5");

        // Preloaded read.
        load_tx(8'h3C);
        run_frame("rd_3c", 8'h51, 8'h00, 8, NO_RST);

        // Other responder's address: ignored.
        run_frame("ign_d3", 8'hD3, 8'h77, 8, NO_RST);

        // Five writes into a depth-4 FIFO with nothing consuming.
        for (int i = 0; i < 5; i++) begin
            run_frame("fill", 8'hD1, 8'hA0 + 8'(i), 8, NO_RST);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pop_one("drain");
        end
        clear_errors();

        // Read with nothing loaded.
        run_frame("rd_empty", 8'h51, 8'h00, 8, NO_RST);
        clear_errors();

        // Deselect after four data bits, then a clean write.
        run_frame("abort4", 8'hD1, 8'h5A, 4, NO_RST);
        run_frame("after_abort", 8'hD1, 8'h11, 8, NO_RST);
        pop_one("after_abort");

        // Reset mid-frame (with a loaded TX byte), then a clean write.
        load_tx(8'h99);
        run_frame("rst_mid", 8'hD1, 8'hC3, 8, 3);
        run_frame("after_rst", 8'hD1, 8'h11, 8, NO_RST);
        pop_one("after_rst");

        // Randomized frames against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'($urandom);
            else cmd[6:0] = ADDR_51 + 7'($urandom_range(0, 4));
            cmd[7] = 1'($urandom);
            data   = 8'($urandom);
            nbits  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 8;
            if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
            run_frame("rand", cmd, data, nbits, NO_RST);
            if (m_q.size() != 0 && $urandom_range(0, 2) != 0) pop_one("rand");
            if ($urandom_range(0, 5) == 0) clear_errors();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
